// File: rtl/axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// axis_pkt_gen
//   AXI4-Stream packet source. Emits num_pkts packets of byte_len bytes each.
//   Packet byte k of packet p carries (k + p) mod 256. Unused lanes on the
//   final beat are driven to zero and masked by TKEEP. A programmable number
//   of idle cycles is inserted between packets.
//
// Ports
//   ACLK, ARESETN      clock, synchronous active-low reset
//   start              run request, sampled only while idle
//   byte_len           bytes per packet        (latched on accepted start)
//   num_pkts           packets per run         (latched on accepted start)
//   gap                idle cycles per gap     (latched on accepted start)
//   busy               run in progress
//   done               one-cycle pulse when a run completes
//   pkts_sent          packets completed in the current / last run
//   M_AXIS_*           AXI4-Stream master (TDATA, TKEEP, TVALID, TREADY, TLAST)
// -----------------------------------------------------------------------------
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; outputs quiet, pkts_sent holds last result
// S_SEND | a beat is presented on the stream, advancing on handshake
// S_GAP  | TVALID low, down-counting the inter-packet idle cycles
//
module axis_pkt_gen #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [LEN_W-1:0]      byte_len,
  input  logic [7:0]            num_pkts,
  input  logic [7:0]            gap,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pkts_sent,
  output logic [DATA_W-1:0]     M_AXIS_TDATA,
  output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;       // bytes left, counting the current beat
  logic [7:0]        npkts_q, npkts_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        pkt_idx_q, pkt_idx_d;
  logic [7:0]        pkts_sent_q, pkts_sent_d;
  logic [7:0]        seed_q, seed_d;     // pattern value of lane 0 on the current beat
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;

  logic              load_beat;
  logic              clear_beat;
  logic [7:0]        ld_seed;
  logic [LEN_W-1:0]  ld_rem;
  beat_t             nxt_beat;

  // Builds one beat from the lane-0 pattern value and the remaining byte
  // count. Lanes beyond the remaining bytes stay zero with TKEEP cleared.
  function automatic beat_t build_beat(input logic [7:0]       seed,
                                       input logic [LEN_W-1:0] rem);
    beat_t b;
    b = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (LEN_W'(i) < rem) begin
        b.keep[i]        = 1'b1;
        b.data[8*i +: 8] = seed + 8'(i);
      end
    end
    b.last = (rem <= LEN_W'(KEEP_W));
    return b;
  endfunction

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      npkts_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      pkt_idx_q   <= '0;
      pkts_sent_q <= '0;
      seed_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      npkts_q     <= npkts_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_idx_q   <= pkt_idx_d;
      pkts_sent_q <= pkts_sent_d;
      seed_q      <= seed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rem_d       = rem_q;
    npkts_d     = npkts_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_idx_d   = pkt_idx_q;
    pkts_sent_d = pkts_sent_q;
    seed_d      = seed_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    load_beat   = 1'b0;
    clear_beat  = 1'b0;
    ld_seed     = seed_q;
    ld_rem      = rem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = byte_len;
          npkts_d     = num_pkts;
          gap_d       = gap;
          pkt_idx_d   = '0;
          pkts_sent_d = '0;
          if (byte_len == '0 || num_pkts == 8'd0) begin
            // Nothing to send: report completion without ever going busy.
            done_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            state_d   = S_SEND;
            load_beat = 1'b1;
            ld_seed   = 8'd0;
            ld_rem    = byte_len;
          end
        end
      end

      S_SEND: begin
        if (tvalid_q && M_AXIS_TREADY) begin
          if (tlast_q) begin
            pkts_sent_d = pkts_sent_q + 8'd1;
            pkt_idx_d   = pkt_idx_q + 8'd1;
            if (pkts_sent_d == npkts_q) begin
              state_d    = S_IDLE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              clear_beat = 1'b1;
            end else if (gap_q == 8'd0) begin
              // Back-to-back: next packet's first beat is valid next cycle.
              load_beat = 1'b1;
              ld_seed   = pkt_idx_d;
              ld_rem    = len_q;
            end else begin
              state_d    = S_GAP;
              gap_cnt_d  = gap_q;
              clear_beat = 1'b1;
            end
          end else begin
            load_beat = 1'b1;
            ld_seed   = seed_q + 8'(KEEP_W);
            ld_rem    = rem_q - LEN_W'(KEEP_W);
          end
        end
      end

      S_GAP: begin
        // The first beat is loaded on the last idle cycle so exactly gap
        // cycles show TVALID low.
        if (gap_cnt_q == 8'd1) begin
          state_d   = S_SEND;
          load_beat = 1'b1;
          ld_seed   = pkt_idx_q;
          ld_rem    = len_q;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    nxt_beat = build_beat(ld_seed, ld_rem);

    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = nxt_beat.data;
      tkeep_d  = nxt_beat.keep;
      tlast_d  = nxt_beat.last;
      seed_d   = ld_seed;
      rem_d    = ld_rem;
    end else if (clear_beat) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pkts_sent     = pkts_sent_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TKEEP  = tkeep_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TLAST  = tlast_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
module tb_axis_pkt_gen;

  logic        ACLK;
  logic        ARESETN;
  logic        start;
  logic [15:0] byte_len;
  logic [7:0]  num_pkts;
  logic [7:0]  gap;
  logic        busy;
  logic        done;
  logic [7:0]  pkts_sent;
  logic [63:0] TDATA;
  logic [7:0]  TKEEP;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;

  int checks   = 0;
  int failures = 0;

  axis_pkt_gen #(.DATA_W(64), .LEN_W(16)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start         (start),
    .byte_len      (byte_len),
    .num_pkts      (num_pkts),
    .gap           (gap),
    .busy          (busy),
    .done          (done),
    .pkts_sent     (pkts_sent),
    .M_AXIS_TDATA  (TDATA),
    .M_AXIS_TKEEP  (TKEEP),
    .M_AXIS_TVALID (TVALID),
    .M_AXIS_TREADY (TREADY),
    .M_AXIS_TLAST  (TLAST)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int len;
    int n;
    int gp;
    int pct;
    int beats;
    int lkeep;
    bit poke;
  } vec_t;

  vec_t vecs [8];

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: packet p, byte k = (k + p) mod 256; beat b covers bytes 8b..8b+7.
  function automatic void exp_beat(input int len, input int p, input int b,
                                   output logic [63:0] d, output logic [7:0] k,
                                   output logic l);
    d = '0;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      int kk;
      kk = 8 * b + i;
      if (kk < len) begin
        d[8*i +: 8] = 8'((kk + p) % 256);
        k[i] = 1'b1;
      end
    end
    l = (8 * (b + 1) >= len);
  endfunction

  task automatic run_case(input int len, input int n, input int gp, input int pct,
                          input int exp_beats, input int exp_lkeep, input bit poke);
    int p, b, cyc, idle;
    bit pending_gap, finished, prev_stall, rdy;
    logic [63:0] pd, ed;
    logic [7:0]  pk, ek;
    logic        pl, el;
    byte_len = 16'(len);
    num_pkts = 8'(n);
    gap      = 8'(gp);
    start    = 1'b1;
    TREADY   = 1'b0;
    tick();
    start = 1'b0;
    chk("start_latency_valid", TVALID, 1);
    p = 0; b = 0; cyc = 0; idle = 0;
    pending_gap = 0; finished = 0; prev_stall = 0;
    pd = '0; pk = '0; pl = 1'b0;
    while (!finished && cyc < 5000) begin
      rdy = ($urandom_range(0, 99) < pct);
      TREADY = rdy;
      if (poke && cyc == 2) begin
        start = 1'b1; byte_len = 16'd5; num_pkts = 8'd9; gap = 8'd4;
      end else begin
        start = 1'b0;
      end
      chk("busy_running", busy, 1);
      chk("done_low_running", done, 0);
      chk("pkts_sent_running", pkts_sent, p);
      if (prev_stall) begin
        chk("stall_valid", TVALID, 1);
        chk("stall_data", TDATA, pd);
        chk("stall_keep", TKEEP, pk);
        chk("stall_last", TLAST, pl);
      end
      if (!TVALID) begin
        idle++;
        if (!pending_gap) chk("valid_mid_pkt", TVALID, 1);
      end else if (pending_gap) begin
        chk("gap_len", idle, gp);
        pending_gap = 0;
      end
      if (TVALID && rdy) begin
        exp_beat(len, p, b, ed, ek, el);
        chk("beat_data", TDATA, ed);
        chk("beat_keep", TKEEP, ek);
        chk("beat_last", TLAST, el);
        if (el) begin
          chk("beats_per_pkt", b + 1, exp_beats);
          chk("last_keep", TKEEP, exp_lkeep);
          p++;
          b = 0;
          if (p == n) finished = 1;
          else begin pending_gap = 1; idle = 0; end
        end else begin
          b++;
        end
      end
      prev_stall = TVALID && !rdy;
      pd = TDATA; pk = TKEEP; pl = TLAST;
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!finished) begin
      chk("run_timeout", cyc, 0);
    end else begin
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      chk("end_valid", TVALID, 0);
      chk("end_pkts_sent", pkts_sent, n);
      tick();
      chk("done_one_cycle", done, 0);
      chk("pkts_sent_hold", pkts_sent, n);
    end
  endtask

  initial begin
    int len, n, gp, pct, lk;
    ARESETN  = 1'b0;
    start    = 1'b0;
    byte_len = '0;
    num_pkts = '0;
    gap      = '0;
    TREADY   = 1'b0;

    vecs[0] = '{len:16,  n:1, gp:0, pct:100, beats:2,  lkeep:'hFF, poke:0};
    vecs[1] = '{len:13,  n:1, gp:0, pct:100, beats:2,  lkeep:'h1F, poke:0};
    vecs[2] = '{len:8,   n:3, gp:2, pct:100, beats:1,  lkeep:'hFF, poke:0};
    vecs[3] = '{len:100, n:4, gp:0, pct:50,  beats:13, lkeep:'h0F, poke:0};
    vecs[4] = '{len:1,   n:3, gp:1, pct:100, beats:1,  lkeep:'h01, poke:0};
    vecs[5] = '{len:9,   n:2, gp:0, pct:60,  beats:2,  lkeep:'h01, poke:0};
    vecs[6] = '{len:24,  n:2, gp:3, pct:100, beats:3,  lkeep:'hFF, poke:1};
    vecs[7] = '{len:64,  n:2, gp:5, pct:70,  beats:8,  lkeep:'hFF, poke:1};

    // Reset values
    tick();
    tick();
    chk("rst_valid", TVALID, 0);
    chk("rst_last", TLAST, 0);
    chk("rst_data", TDATA, 0);
    chk("rst_keep", TKEEP, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pkts_sent", pkts_sent, 0);
    ARESETN = 1'b1;
    tick();

    // Exact 16-byte packet
    byte_len = 16'd16; num_pkts = 8'd1; gap = 8'd0; TREADY = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p16_b0_data", TDATA, 64'h0706050403020100);
    chk("p16_b0_keep", TKEEP, 8'hFF);
    chk("p16_b0_last", TLAST, 0);
    tick();
    chk("p16_b1_data", TDATA, 64'h0F0E0D0C0B0A0908);
    chk("p16_b1_last", TLAST, 1);
    tick();
    chk("p16_done", done, 1);
    chk("p16_busy", busy, 0);
    chk("p16_pkts_sent", pkts_sent, 1);
    tick();

    // Exact 13-byte packet
    byte_len = 16'd13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("p13_b1_data", TDATA, 64'h0000000C0B0A0908);
    chk("p13_b1_keep", TKEEP, 8'h1F);
    chk("p13_b1_last", TLAST, 1);
    tick();
    tick();

    // Degenerate: byte_len = 0 (pkts_sent is 1 beforehand)
    byte_len = 16'd0; num_pkts = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", TVALID, 0);
    chk("len0_pkts_sent", pkts_sent, 0);
    tick();
    chk("len0_done_drop", done, 0);
    chk("len0_valid2", TVALID, 0);

    // Degenerate: num_pkts = 0
    byte_len = 16'd5; num_pkts = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_valid", TVALID, 0);
    tick();

    // Reset during beat 2 of a 32-byte packet
    byte_len = 16'd32; num_pkts = 8'd1; gap = 8'd0; TREADY = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("rm_beat2_data", TDATA, 64'h1716151413121110);
    ARESETN = 1'b0;
    tick();
    ARESETN = 1'b1;
    chk("rm_valid", TVALID, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", done, 0);
    chk("rm_pkts_sent", pkts_sent, 0);
    chk("rm_data", TDATA, 0);
    tick();
    chk("rm_no_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_restart_data", TDATA, 64'h0706050403020100);
    tick(); tick(); tick(); tick();
    chk("rm_restart_done", done, 1);
    tick();

    // Reset after one packet of a multi-packet run clears pkts_sent
    byte_len = 16'd8; num_pkts = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rp_pkt1_lane0", TDATA[7:0], 8'h01);
    chk("rp_pkts_sent", pkts_sent, 1);
    ARESETN = 1'b0;
    tick();
    chk("rp_pkts_sent_clr", pkts_sent, 0);
    chk("rp_valid", TVALID, 0);
    chk("rp_done", done, 0);

    // Start coincident with reset is ignored
    start = 1'b1;
    tick();
    ARESETN = 1'b1;
    start = 1'b0;
    chk("rs_valid", TVALID, 0);
    chk("rs_busy", busy, 0);
    tick();
    chk("rs_valid2", TVALID, 0);
    chk("rs_busy2", busy, 0);
    chk("rs_done2", done, 0);

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      run_case(vecs[i].len, vecs[i].n, vecs[i].gp, vecs[i].pct,
               vecs[i].beats, vecs[i].lkeep, vecs[i].poke);
      tick();
    end

    // Randomized runs
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 80);
      n   = $urandom_range(1, 4);
      gp  = $urandom_range(0, 3);
      pct = $urandom_range(30, 100);
      lk  = (len % 8 == 0) ? 'hFF : ((1 << (len % 8)) - 1);
      run_case(len, n, gp, pct, (len + 7) / 8, lk, (i % 2) == 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
